des_round_ctrl: RTL

Round sequencer for the iterative DES engine. Accepts a PC-1-permuted 56-bit key and a start request. Owns the C/D key-schedule registers and drives an external single-round datapath through a req/ack handshake for 16 rounds. Holds the result-valid handshake toward the consumer until the consumer accepts it. It sits between the top-level encrypt/decrypt front end and the round datapath.

---
 rtl/des_round_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES engine: owns the C/D key-schedule
// registers and paces an external single-round datapath over NUM_ROUNDS rounds.
module des_round_ctrl #(
  parameter int          NUM_ROUNDS = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h7EFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] key,
  output logic        ready,
  output logic        load_data,
  output logic        round_req,
  input  logic        round_ack,
  output logic [4:0]  round_idx,
  output logic [55:0] round_cd,
  output logic        last_round,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [55:0] cd_reg, cd_next;
  logic [4:0]  idx_reg, idx_next;
  logic        dir_reg, dir_next;

  // Shared rotator: one operand/amount/direction selection feeds both halves.
  logic [55:0] rot_src;
  logic [55:0] rot_out;
  logic [1:0]  rot_amt;
  logic        rot_right;
  logic [4:0]  dec_sel;

  // Decrypt round r' uses mask bit NUM_ROUNDS+1-r'; with r' = idx+1 that is NUM_ROUNDS-idx.
  assign dec_sel = LAST_IDX - idx_reg;

  always_comb begin
    rot_src   = cd_reg;
    rot_amt   = 2'd0;
    rot_right = dir_reg;
    if (state_reg == S_IDLE) begin
      rot_src   = key;
      rot_right = 1'b0;
      rot_amt   = decrypt ? 2'd0 : 2'd1;
    end else if (dir_reg) begin
      rot_amt = 2'd1 + {1'b0, SHIFT_MASK[dec_sel[3:0]]};
    end else begin
      rot_amt = 2'd1 + {1'b0, SHIFT_MASK[idx_reg[3:0]]};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      logic [27:0] half_in;
      logic [27:0] half_out;

      assign half_in = rot_src[gi*28 +: 28];

      // Each 28-bit half wraps within itself.
      always_comb begin
        half_out = half_in;
        case (rot_amt)
          2'd1: half_out = rot_right ? {half_in[0], half_in[27:1]}
                                     : {half_in[26:0], half_in[27]};
          2'd2: half_out = rot_right ? {half_in[1:0], half_in[27:2]}
                                     : {half_in[25:0], half_in[27:26]};
          default: half_out = half_in;
        endcase
      end

      assign rot_out[gi*28 +: 28] = half_out;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cd_reg    <= '0;
      idx_reg   <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      idx_reg   <= idx_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cd_next    = cd_reg;
    idx_next   = idx_reg;
    dir_next   = dir_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          dir_next   = decrypt;
          cd_next    = rot_out;
          idx_next   = 5'd1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = S_ROUND;
      end
      S_ROUND: begin
        if (round_ack) begin
          if (idx_reg < LAST_IDX) begin
            idx_next = idx_reg + 5'd1;
            cd_next  = rot_out;
          end else begin
            idx_next   = 5'd0;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; nothing combinational from the inputs.
  assign ready      = (state_reg == S_IDLE);
  assign load_data  = (state_reg == S_LOAD);
  assign round_req  = (state_reg == S_ROUND);
  assign round_idx  = round_req ? idx_reg : 5'd0;
  assign round_cd   = round_req ? cd_reg : 56'd0;
  assign last_round = round_req && (idx_reg == LAST_IDX);
  assign out_valid  = (state_reg == S_DONE);

endmodule
